// File: rtl/cw_output.sv
// Clockwise output stage: one 1-flit buffer per VC (even/odd), per-VC round-robin
// between the CW and PE requestors, hop decrement on capture, polarity-selected send.
module cw_output #(
  parameter int DATA_WIDTH = 64,
  parameter int HOP_MSB    = 55,
  parameter int HOP_LSB    = 48,
  parameter int RR_RESET   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  request_cw_even,
  input  logic                  request_cw_odd,
  input  logic                  request_pe_even,
  input  logic                  request_pe_odd,
  input  logic [DATA_WIDTH-1:0] data_in_cw_even,
  input  logic [DATA_WIDTH-1:0] data_in_cw_odd,
  input  logic [DATA_WIDTH-1:0] data_in_pe_even,
  input  logic [DATA_WIDTH-1:0] data_in_pe_odd,
  output logic                  grant_cw_even,
  output logic                  grant_cw_odd,
  output logic                  grant_pe_even,
  output logic                  grant_pe_odd,
  input  logic                  cwro,
  output logic                  cwso,
  output logic [DATA_WIDTH-1:0] cwdo
);

  localparam int HOP_W = HOP_MSB - HOP_LSB + 1;

  typedef enum logic {
    RR_CW = 1'b0,
    RR_PE = 1'b1
  } rr_e;

  localparam rr_e RR_INIT = (RR_RESET == 0) ? RR_CW : RR_PE;

  // Index 0 is the even VC, index 1 the odd VC.
  logic [1:0]                 req_cw, req_pe;
  logic [1:0]                 gnt_cw, gnt_pe;
  logic [1:0][DATA_WIDTH-1:0] din_cw, din_pe;

  logic [1:0]                 full_q, full_d;
  logic [1:0][DATA_WIDTH-1:0] buf_q, buf_d;
  rr_e                        rr_q [2];
  rr_e                        rr_d [2];
  logic                       cwso_q, cwso_d;
  logic [DATA_WIDTH-1:0]      cwdo_q, cwdo_d;
  logic                       sel_vc;

  assign req_cw = {request_cw_odd, request_cw_even};
  assign req_pe = {request_pe_odd, request_pe_even};
  assign din_cw = {data_in_cw_odd, data_in_cw_even};
  assign din_pe = {data_in_pe_odd, data_in_pe_even};

  assign grant_cw_even = gnt_cw[0];
  assign grant_cw_odd  = gnt_cw[1];
  assign grant_pe_even = gnt_pe[0];
  assign grant_pe_odd  = gnt_pe[1];

  assign sel_vc = ~polarity;
  assign cwso   = cwso_q;
  assign cwdo   = cwdo_q;

  function automatic logic [DATA_WIDTH-1:0] dec_hop(input logic [DATA_WIDTH-1:0] flit);
    logic [DATA_WIDTH-1:0] f;
    logic [HOP_W-1:0]      hop;
    f   = flit;
    hop = flit[HOP_MSB:HOP_LSB];
    if (hop != '0) hop = hop - 1'b1;
    f[HOP_MSB:HOP_LSB] = hop;
    return f;
  endfunction

  always_comb begin
    gnt_cw = '0;
    gnt_pe = '0;
    full_d = full_q;
    buf_d  = buf_q;
    rr_d   = rr_q;
    cwso_d = 1'b0;
    cwdo_d = cwdo_q;

    if (full_q[sel_vc] && cwro) begin
      cwso_d         = 1'b1;
      cwdo_d         = buf_q[sel_vc];
      full_d[sel_vc] = 1'b0;
    end

    // Grants look only at the pre-edge full flag, so a buffer freed by the send
    // above cannot be refilled in the same cycle.
    for (int unsigned v = 0; v < 2; v++) begin
      if (rst && !full_q[v]) begin
        if (req_cw[v] && (!req_pe[v] || rr_q[v] == RR_CW)) gnt_cw[v] = 1'b1;
        else if (req_pe[v])                                 gnt_pe[v] = 1'b1;
      end
      if (gnt_cw[v]) begin
        buf_d[v]  = dec_hop(din_cw[v]);
        full_d[v] = 1'b1;
        rr_d[v]   = RR_PE;
      end else if (gnt_pe[v]) begin
        buf_d[v]  = dec_hop(din_pe[v]);
        full_d[v] = 1'b1;
        rr_d[v]   = RR_CW;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q  <= '0;
      buf_q   <= '0;
      rr_q[0] <= RR_INIT;
      rr_q[1] <= RR_INIT;
      cwso_q  <= 1'b0;
      cwdo_q  <= '0;
    end else begin
      full_q  <= full_d;
      buf_q   <= buf_d;
      rr_q    <= rr_d;
      cwso_q  <= cwso_d;
      cwdo_q  <= cwdo_d;
    end
  end

endmodule

// File: tb/tb_cw_output.sv
// Randomized bench for cw_output: queue-based reference of per-VC buffers and
// round-robin order; a monitor checks every link edge against the expected flits.
module tb_cw_output;

  localparam int DW = 64;
  localparam int HM = 55;
  localparam int HL = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic          polarity;
  logic          cwro;
  logic          req [4];   // 0 cw_even, 1 cw_odd, 2 pe_even, 3 pe_odd
  logic [DW-1:0] dat [4];
  logic [3:0]    gnt;
  logic          cwso;
  logic [DW-1:0] cwdo;

  cw_output #(.DATA_WIDTH(DW), .HOP_MSB(HM), .HOP_LSB(HL), .RR_RESET(0)) dut (
    .clk(clk), .rst(rst), .polarity(polarity),
    .request_cw_even(req[0]), .request_cw_odd(req[1]),
    .request_pe_even(req[2]), .request_pe_odd(req[3]),
    .data_in_cw_even(dat[0]), .data_in_cw_odd(dat[1]),
    .data_in_pe_even(dat[2]), .data_in_pe_odd(dat[3]),
    .grant_cw_even(gnt[0]), .grant_cw_odd(gnt[1]),
    .grant_pe_even(gnt[2]), .grant_pe_odd(gnt[3]),
    .cwro(cwro), .cwso(cwso), .cwdo(cwdo)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: a queue per VC holds the flit expected in that buffer.
  logic [DW-1:0] q_even[$];
  logic [DW-1:0] q_odd[$];
  bit            fresh [2];
  bit            pe_next [2];
  logic [DW-1:0] last_cwdo;
  bit            granted [4];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int v);
    return (v == 0) ? q_even.size() : q_odd.size();
  endfunction

  function automatic void q_push(input int v, input logic [DW-1:0] d);
    if (v == 0) q_even.push_back(d);
    else        q_odd.push_back(d);
  endfunction

  function automatic logic [DW-1:0] q_pop(input int v);
    if (v == 0) return q_even.pop_front();
    return q_odd.pop_front();
  endfunction

  function automatic logic [DW-1:0] expect_out(input logic [DW-1:0] f);
    logic [DW-1:0] r;
    int unsigned   h;
    r = f;
    h = int'(f[HM:HL]);
    if (h > 0) h = h - 1;
    r[HM:HL] = h[7:0];
    return r;
  endfunction

  function automatic logic [DW-1:0] new_flit();
    logic [DW-1:0] f;
    logic [7:0]    hop;
    f = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       hop = 8'd0;
      1:       hop = 8'd1;
      2:       hop = 8'd3;
      default: hop = 8'($urandom_range(0, 255));
    endcase
    f[HM:HL] = hop;
    return f;
  endfunction

  function automatic void model_reset();
    q_even.delete();
    q_odd.delete();
    fresh[0]   = 1'b0;
    fresh[1]   = 1'b0;
    pe_next[0] = 1'b0;
    pe_next[1] = 1'b0;
    last_cwdo  = '0;
  endfunction

  // Monitor: just after each edge, decide from the reference whether a flit left.
  initial begin
    int sel;
    logic [DW-1:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        check("reset_cwso", {63'd0, cwso}, '0);
        check("reset_cwdo", cwdo, '0);
        last_cwdo = '0;
      end else begin
        sel = polarity ? 0 : 1;
        if (q_size(sel) > 0 && !fresh[sel] && cwro) begin
          exp = q_pop(sel);
          check("cwso_send", {63'd0, cwso}, 64'd1);
          check("cwdo_flit", cwdo, exp);
          last_cwdo = exp;
        end else begin
          check("cwso_idle", {63'd0, cwso}, '0);
          check("cwdo_hold", cwdo, last_cwdo);
        end
      end
      fresh[0] = 1'b0;
      fresh[1] = 1'b0;
    end
  end

  // Driver: checks grants against the arbitration rules and pushes granted flits.
  initial begin
    bit   armed;
    bit   did_reset;
    int   rst_hold;
    logic [3:0] exp_g;

    armed     = 1'b0;
    did_reset = 1'b0;
    rst_hold  = 0;
    rst       = 1'b0;
    polarity  = 1'b1;
    cwro      = 1'b1;
    for (int s = 0; s < 4; s++) begin
      req[s]     = 1'b1;
      dat[s]     = new_flit();
      granted[s] = 1'b0;
    end
    model_reset();

    repeat (3) begin
      @(negedge clk);
      check("reset_grants", {60'd0, gnt}, '0);
      check("reset_cwso_n", {63'd0, cwso}, '0);
      check("reset_cwdo_n", cwdo, '0);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;

    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      exp_g = '0;
      for (int v = 0; v < 2; v++) begin
        granted[v]     = 1'b0;
        granted[2 + v] = 1'b0;
        if (rst && q_size(v) == 0) begin
          if (req[v] && req[2 + v]) granted[pe_next[v] ? 2 + v : v] = 1'b1;
          else if (req[v])          granted[v] = 1'b1;
          else if (req[2 + v])      granted[2 + v] = 1'b1;
        end
        if (granted[v]) begin
          q_push(v, expect_out(dat[v]));
          fresh[v]   = 1'b1;
          pe_next[v] = 1'b1;
        end else if (granted[2 + v]) begin
          q_push(v, expect_out(dat[2 + v]));
          fresh[v]   = 1'b1;
          pe_next[v] = 1'b0;
        end
      end
      for (int s = 0; s < 4; s++) exp_g[s] = granted[s];
      check("grants", {60'd0, gnt}, {60'd0, exp_g});

      @(posedge clk);
      #2;

      for (int s = 0; s < 4; s++) begin
        if (granted[s]) begin
          if ($urandom_range(0, 3) != 0) dat[s] = new_flit();
          else                           req[s] = 1'b0;
        end else if (!req[s] && $urandom_range(0, 1) == 1) begin
          req[s] = 1'b1;
          dat[s] = new_flit();
        end
      end

      if (cyc >= 100 && cyc < 115)      cwro = 1'b0;
      else if (armed)                   cwro = 1'b1;
      else                              cwro = ($urandom_range(0, 4) != 0);

      if (cyc >= 450 && cyc < 480) polarity = 1'($urandom_range(0, 1));
      else                         polarity = ~polarity;

      if (cyc == 300) armed = 1'b1;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b1;
      end else if (armed && !did_reset && cwso && q_odd.size() > 0) begin
        rst = 1'b0;
        #1;
        check("async_cwso", {63'd0, cwso}, '0);
        check("async_grants", {60'd0, gnt}, '0);
        model_reset();
        did_reset = 1'b1;
        armed     = 1'b0;
        rst_hold  = 3;
      end
    end

    check("mid_reset_hit", {63'd0, did_reset}, 64'd1);
    @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
